// File: rtl/dct2d_pkg.sv
// Shared types and constants for the 2-D DCT sequencer and its buffers.
package dct2d_pkg;
   localparam int N      = 8;
   localparam int CNT_W  = 4;
   localparam int IDX_W  = 3;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      ROW_ISSUE,
      ROW_DRAIN,
      COL_ISSUE,
      COL_DRAIN,
      EMIT
   } dct2d_state_e;

   typedef logic [N-1:0][WORD_W-1:0] vec8_t;
endpackage

// File: rtl/dct2d_seq_ctrl_if.sv
// Streaming input, core issue/return and streaming output of the DCT sequencer.
interface dct2d_seq_ctrl_if #(
   parameter int DATA_W = 32
);
   import dct2d_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [N-1:0][DATA_W-1:0] in_row;
   logic                     core_valid_in;
   logic [N-1:0][DATA_W-1:0] core_data_in;
   logic                     core_valid_out;
   logic [N-1:0][DATA_W-1:0] core_data_out;
   logic                     out_valid;
   logic                     out_ready;
   logic [N-1:0][DATA_W-1:0] out_row;
   logic                     out_last;

   modport slave (
      input  in_valid, in_row, core_valid_out, core_data_out, out_ready,
      output in_ready, core_valid_in, core_data_in, out_valid, out_row, out_last
   );

   modport master (
      output in_valid, in_row, core_valid_out, core_data_out, out_ready,
      input  in_ready, core_valid_in, core_data_in, out_valid, out_row, out_last
   );
endinterface

// File: rtl/dct2d_tbuf.sv
// 8x8 word array with one write port (row or column) and one read port (row or column).
module dct2d_tbuf
   import dct2d_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     wr_col,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [N-1:0][DATA_W-1:0] wr_data,
   input  logic                     rd_col,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [N-1:0][DATA_W-1:0] rd_data
);
   logic [N-1:0][N-1:0][DATA_W-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         if (wr_col) begin
            for (int r = 0; r < N; r++) mem_d[r][wr_idx] = wr_data[r];
         end else begin
            mem_d[wr_idx] = wr_data;
         end
      end
   end

   // Contents are meaningless outside a block, so the array carries no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data = mem_q[rd_idx];
      if (rd_col) begin
         for (int r = 0; r < N; r++) rd_data[r] = mem_q[r][rd_idx];
      end
   end
endmodule

// File: rtl/dct2d_seq_ctrl.sv
// 2-D 8x8 DCT sequencer time-sharing one external 8-point 1-D core:
// rows -> transpose buffer, columns -> output buffer, then rows streamed out.
module dct2d_seq_ctrl
   import dct2d_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MID_SHIFT = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   dct2d_seq_ctrl_if.slave bus,
   output logic            busy,
   output logic            err_unexpected,
   output logic            err_timeout
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   typedef logic [N-1:0][DATA_W-1:0] row_t;

   dct2d_state_e     state_q, state_d;
   logic [IDX_W-1:0] in_cnt_q, in_cnt_d, col_q, col_d, emit_q, emit_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d, outst_q, outst_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             cvi_q, cvi_d, err_unexp_q, err_unexp_d, err_tmo_q, err_tmo_d;
   row_t             cdi_q, cdi_d, shifted, tbuf_col, obuf_row;
   logic             in_acc, in_fire, res_ok, row_pass, col_pass, draining;
   logic             rcnt_full, tmo_hit, out_fire;

   always_comb begin
      in_acc    = (state_q == IDLE) || (state_q == ROW_ISSUE);
      in_fire   = in_acc && bus.in_valid;
      res_ok    = bus.core_valid_out && (outst_q != '0);
      row_pass  = (state_q == ROW_ISSUE) || (state_q == ROW_DRAIN);
      col_pass  = (state_q == COL_ISSUE) || (state_q == COL_DRAIN);
      draining  = (state_q == ROW_DRAIN) || (state_q == COL_DRAIN);
      rcnt_full = (rcnt_q == CNT_W'(N));
      tmo_hit   = draining && !rcnt_full && !bus.core_valid_out &&
                  (tmo_q == TMO_W'(TIMEOUT - 1));
      out_fire  = (state_q == EMIT) && bus.out_ready;
   end

   // Inter-pass renormalisation keeps the sign of the row result.
   always_comb begin
      for (int c = 0; c < N; c++)
         shifted[c] = DATA_W'($signed(bus.core_data_out[c]) >>> MID_SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (bus.in_valid) state_d = ROW_ISSUE;
         ROW_ISSUE: if (in_fire && in_cnt_q == IDX_W'(N - 1)) state_d = ROW_DRAIN;
         ROW_DRAIN: if (rcnt_full) state_d = COL_ISSUE;
                    else if (tmo_hit) state_d = IDLE;
         COL_ISSUE: if (col_q == IDX_W'(N - 1)) state_d = COL_DRAIN;
         COL_DRAIN: if (rcnt_full) state_d = EMIT;
                    else if (tmo_hit) state_d = IDLE;
         EMIT:      if (out_fire && emit_q == IDX_W'(N - 1)) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      in_cnt_d    = in_cnt_q;
      col_d       = col_q;
      emit_d      = emit_q;
      rcnt_d      = rcnt_q;
      tmo_d       = '0;
      cvi_d       = 1'b0;
      cdi_d       = cdi_q;
      outst_d     = outst_q + CNT_W'(cvi_q) - CNT_W'(res_ok);
      err_unexp_d = err_unexp_q || (bus.core_valid_out && outst_q == '0);
      err_tmo_d   = err_tmo_q || tmo_hit;

      if (in_fire) begin
         in_cnt_d = (in_cnt_q == IDX_W'(N - 1)) ? '0 : in_cnt_q + IDX_W'(1);
         cvi_d    = 1'b1;
         cdi_d    = bus.in_row;
      end
      if (state_q == COL_ISSUE) begin
         cvi_d = 1'b1;
         cdi_d = tbuf_col;
         col_d = col_q + IDX_W'(1);
      end
      if (res_ok) rcnt_d = rcnt_q + CNT_W'(1);
      if (draining && !rcnt_full && !bus.core_valid_out && !tmo_hit) tmo_d = tmo_q + TMO_W'(1);
      // A finished pass or an abandoned block restarts the return bookkeeping.
      if ((draining && rcnt_full) || tmo_hit) rcnt_d = '0;
      if (tmo_hit) outst_d = '0;
      if (out_fire) emit_d = emit_q + IDX_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_q    <= '0;
         col_q       <= '0;
         emit_q      <= '0;
         rcnt_q      <= '0;
         outst_q     <= '0;
         tmo_q       <= '0;
         cvi_q       <= 1'b0;
         cdi_q       <= '0;
         err_unexp_q <= 1'b0;
         err_tmo_q   <= 1'b0;
      end else begin
         in_cnt_q    <= in_cnt_d;
         col_q       <= col_d;
         emit_q      <= emit_d;
         rcnt_q      <= rcnt_d;
         outst_q     <= outst_d;
         tmo_q       <= tmo_d;
         cvi_q       <= cvi_d;
         cdi_q       <= cdi_d;
         err_unexp_q <= err_unexp_d;
         err_tmo_q   <= err_tmo_d;
      end
   end

   always_comb begin
      bus.in_ready      = rst_n && in_acc;
      bus.core_valid_in = cvi_q;
      bus.core_data_in  = cdi_q;
      bus.out_valid     = (state_q == EMIT);
      bus.out_row       = (state_q == EMIT) ? obuf_row : '0;
      bus.out_last      = (state_q == EMIT) && (emit_q == IDX_W'(N - 1));
      busy              = (state_q != IDLE);
      err_unexpected    = err_unexp_q;
      err_timeout       = err_tmo_q;
   end

   dct2d_tbuf #(.DATA_W(DATA_W)) u_tbuf (
      .clk     (clk),
      .we      (res_ok && row_pass),
      .wr_col  (1'b0),
      .wr_idx  (rcnt_q[IDX_W-1:0]),
      .wr_data (shifted),
      .rd_col  (1'b1),
      .rd_idx  (col_q),
      .rd_data (tbuf_col)
   );

   dct2d_tbuf #(.DATA_W(DATA_W)) u_obuf (
      .clk     (clk),
      .we      (res_ok && col_pass),
      .wr_col  (1'b1),
      .wr_idx  (rcnt_q[IDX_W-1:0]),
      .wr_data (bus.core_data_out),
      .rd_col  (1'b0),
      .rd_idx  (emit_q),
      .rd_data (obuf_row)
   );
endmodule

// File: tb/tb_dct2d_seq_ctrl.sv
// Bench for dct2d_seq_ctrl: two instances (MID_SHIFT 0 / 1) sharing one scalar core model.
module tb_dct2d_seq_ctrl;
   import dct2d_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  sel = 1'b0;
   logic  in_valid = 1'b0;
   logic  out_ready = 1'b0;
   vec8_t in_row = '0;
   logic  cvo = 1'b0;
   vec8_t cdo = '0;
   logic  busy_a, busy_b, eu_a, eu_b, et_a, et_b;

   dct2d_seq_ctrl_if #(.DATA_W(32)) ifa ();
   dct2d_seq_ctrl_if #(.DATA_W(32)) ifb ();

   assign ifa.in_valid       = in_valid & ~sel;
   assign ifb.in_valid       = in_valid & sel;
   assign ifa.in_row         = in_row;
   assign ifb.in_row         = in_row;
   assign ifa.out_ready      = out_ready;
   assign ifb.out_ready      = out_ready;
   assign ifa.core_valid_out = cvo & ~sel;
   assign ifb.core_valid_out = cvo & sel;
   assign ifa.core_data_out  = cdo;
   assign ifb.core_data_out  = cdo;

   dct2d_seq_ctrl #(.DATA_W(32), .MID_SHIFT(0), .TIMEOUT(20)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa),
      .busy(busy_a), .err_unexpected(eu_a), .err_timeout(et_a));

   dct2d_seq_ctrl #(.DATA_W(32), .MID_SHIFT(1), .TIMEOUT(255)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb),
      .busy(busy_b), .err_unexpected(eu_b), .err_timeout(et_b));

   logic  in_ready_m, cvi_m, out_valid_m, out_last_m, busy_m, eu_m, et_m;
   vec8_t cdi_m, out_row_m;
   assign in_ready_m  = sel ? ifb.in_ready      : ifa.in_ready;
   assign cvi_m       = sel ? ifb.core_valid_in : ifa.core_valid_in;
   assign cdi_m       = sel ? ifb.core_data_in  : ifa.core_data_in;
   assign out_valid_m = sel ? ifb.out_valid     : ifa.out_valid;
   assign out_row_m   = sel ? ifb.out_row       : ifa.out_row;
   assign out_last_m  = sel ? ifb.out_last      : ifa.out_last;
   assign busy_m      = sel ? busy_b : busy_a;
   assign eu_m        = sel ? eu_b   : eu_a;
   assign et_m        = sel ? et_b   : et_a;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   // Scalar-gain core with fixed latency; can drop one result or inject a stray one.
   int    lat = 3;
   int    gain = 1;
   int    res_cnt = 0;
   int    drop_at = -1;
   bit    inj_req = 1'b0;
   bit    pv [16];
   vec8_t pd [16];

   always @(negedge clk) begin
      for (int i = 15; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = cvi_m;
      pd[0] = cdi_m;
      cvo = 1'b0;
      cdo = '0;
      if (pv[lat-1]) begin
         if (res_cnt != drop_at) begin
            cvo = 1'b1;
            for (int c = 0; c < N; c++) cdo[c] = 32'(int'(pd[lat-1][c]) * gain);
         end
         res_cnt++;
      end
      if (inj_req) begin
         cvo = 1'b1;
         cdo = {8{32'h0BAD_F00D}};
         inj_req = 1'b0;
      end
   end

   int X [8][8];
   int Y [8][8];

   // Reference: each row through the core, renormalise, then each column through the core.
   task automatic compute(input int g, input int sh);
      int t [8][8];
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) t[r][c] = (g * X[r][c]) >>> sh;
      for (int j = 0; j < 8; j++)
         for (int r = 0; r < 8; r++) Y[r][j] = g * t[r][j];
   endtask

   task automatic fill(input int mode);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            case (mode)
               0: X[r][c] = r * 8 + c;
               1: X[r][c] = 32'h10;
               2: X[r][c] = -16;
               default: X[r][c] = int'($urandom);
            endcase
   endtask

   task automatic run_block(input string tag, input int gap_mode, input int stall_mode,
                            input bit stop_at_emit);
      int    sent = 0, got = 0, cyc = 0;
      bit    done = 1'b0, ir_bad = 1'b0, pvld = 1'b0, prdy = 1'b0;
      vec8_t prow = '0, exp;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (sent < 8) begin
            case (gap_mode)
               0:       in_valid = 1'b1;
               1:       in_valid = (cyc % 3 != 0);
               default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            for (int c = 0; c < 8; c++) in_row[c] = X[sent][c];
         end else begin
            in_valid = 1'b0;
         end
         case (stall_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 1);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         if (sent == 8 && in_ready_m) ir_bad = 1'b1;
         if (pvld && !prdy) begin
            check({tag, "_hold_vld"}, out_valid_m, 1'b1);
            check({tag, "_hold_row"}, out_row_m, prow);
         end
         if (stop_at_emit && out_valid_m) begin
            done = 1'b1;
         end else if (out_valid_m && out_ready) begin
            for (int c = 0; c < 8; c++) exp[c] = Y[got][c];
            check($sformatf("%s_row%0d", tag, got), out_row_m, exp);
            check($sformatf("%s_last%0d", tag, got), out_last_m, (got == 7));
            got++;
            if (got == 8) done = 1'b1;
         end
         if (in_valid && in_ready_m) sent++;
         pvld = out_valid_m;
         prdy = out_ready;
         prow = out_row_m;
      end
      in_valid = 1'b0;
      check({tag, "_inrdy_low"}, ir_bad, 1'b0);
      if (!stop_at_emit) begin
         check({tag, "_rows"}, got, 8);
         @(negedge clk);
         check({tag, "_idle"}, busy_m, 1'b0);
      end else begin
         check({tag, "_emit"}, done, 1'b1);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, in_ready_m, 1'b0);
      check({tag, "_cvi"}, cvi_m, 1'b0);
      check({tag, "_cdi"}, cdi_m, '0);
      check({tag, "_out_valid"}, out_valid_m, 1'b0);
      check({tag, "_out_last"}, out_last_m, 1'b0);
      check({tag, "_out_row"}, out_row_m, '0);
      check({tag, "_busy"}, busy_m, 1'b0);
      check({tag, "_errs"}, {eu_m, et_m}, 2'b00);
   endtask

   initial begin
      int last, gap, cyc, sent;
      bit seen;

      repeat (3) @(negedge clk);
      sel = 1'b0;
      #1 check_reset_vals("rst_a");
      sel = 1'b1;
      #1 check_reset_vals("rst_b");
      sel = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready_m, 1'b1);

      lat = 3; gain = 1;
      fill(0); compute(1, 0); run_block("ramp", 0, 0, 1'b0);
      fill(0); compute(1, 0); run_block("stall", 1, 1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         fill(3); compute(1, 0); run_block($sformatf("rnd_a%0d", k), 2, 2, 1'b0);
      end

      sel = 1'b1; lat = 5; gain = 2;
      @(negedge clk);
      fill(1); compute(2, 1); run_block("dbl_pos", 0, 0, 1'b0);
      fill(2); compute(2, 1); run_block("dbl_neg", 1, 1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         fill(3); compute(2, 1); run_block($sformatf("rnd_b%0d", k), 2, 2, 1'b0);
      end
      check("b_errs", {eu_m, et_m}, 2'b00);

      sel = 1'b0; lat = 3; gain = 1;
      @(posedge clk);
      inj_req = 1'b1;
      repeat (2) @(negedge clk);
      check("inj_err", eu_m, 1'b1);
      check("inj_busy", busy_m, 1'b0);
      fill(3); compute(1, 0); run_block("post_inj", 2, 1, 1'b0);
      check("inj_sticky", eu_m, 1'b1);

      fill(3);
      drop_at = res_cnt + 7;
      sent = 0;
      cyc = 0;
      while (sent < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b1;
         for (int c = 0; c < 8; c++) in_row[c] = X[sent][c];
         if (in_ready_m) sent++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("tmo_sent", sent, 8);
      last = -1; seen = 1'b0; gap = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (ifa.core_valid_out) last = i;
         if (et_a) begin
            seen = 1'b1;
            gap = i - last;
         end
      end
      check("tmo_flag", seen, 1'b1);
      check("tmo_within", (last >= 0 && gap >= 1 && gap <= 20), 1'b1);
      check("tmo_idle", busy_m, 1'b0);
      check("tmo_in_ready", in_ready_m, 1'b1);

      fill(0); compute(1, 0); run_block("hold", 0, 3, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst_emit");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", in_ready_m, 1'b1);
      fill(3); compute(1, 0); run_block("after_rst", 2, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
